// File: rtl/rvx_lpixm_rr_arbiter_pkg.sv
// Shared lpixm parcel layout: field widths, parcel sizes and field extractors
// used by the two-requester round-robin arbiter and its route FIFO.
package rvx_lpixm_rr_arbiter_pkg;

    localparam int BW_AXI_ALEN       = 8;
    localparam int BW_AXI_ASIZE      = 3;
    localparam int BW_AXI_ABURST     = 2;
    localparam int BW_LPIXM_RESP     = 2;
    localparam int BW_ROUTE_ENTRY    = 1 + BW_AXI_ALEN;
    localparam int LPIXM_PARCEL_MAX  = 1024;

    typedef logic [LPIXM_PARCEL_MAX-1:0] lpixm_parcel_max_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    // q parcel = {burden, write, alen, asize, aburst, byte-enable, wdata, addr}
    function automatic int lpixm_qparcel_width(int bw_addr, int bw_data, int bw_burden);
        return bw_burden + 1 + BW_AXI_ALEN + BW_AXI_ASIZE + BW_AXI_ABURST
             + bw_data / 8 + bw_data + bw_addr;
    endfunction

    // y parcel = {burden, resp, rdata}
    function automatic int lpixm_yparcel_width(int bw_data, int bw_burden);
        return bw_burden + BW_LPIXM_RESP + bw_data;
    endfunction

    function automatic int lpixm_alen_pos(int bw_addr, int bw_data);
        return bw_addr + bw_data + bw_data / 8 + BW_AXI_ABURST + BW_AXI_ASIZE;
    endfunction

    function automatic logic lpixm_get_write(lpixm_parcel_max_t parcel, int bw_addr, int bw_data);
        lpixm_parcel_max_t shifted;
        shifted = parcel >> (lpixm_alen_pos(bw_addr, bw_data) + BW_AXI_ALEN);
        return shifted[0];
    endfunction

    function automatic logic [BW_AXI_ALEN-1:0] lpixm_get_alen(lpixm_parcel_max_t parcel,
                                                             int bw_addr, int bw_data);
        lpixm_parcel_max_t shifted;
        shifted = parcel >> lpixm_alen_pos(bw_addr, bw_data);
        return shifted[BW_AXI_ALEN-1:0];
    endfunction

endpackage

// File: rtl/rvx_lpixm_rr_arbiter_route.sv
// Route FIFO: remembers, in issue order, which requester owns each outstanding
// burst and how many response beats (minus one) it will return.
module rvx_route_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvx_lpixm_rr_arbiter.sv
// Two-requester round-robin arbiter onto one lpixm slave; write bursts lock the
// q channel to their owner and responses are steered back in issue order.
module rvx_lpixm_rr_arbiter
    import rvx_lpixm_rr_arbiter_pkg::*;
#(
    parameter int BW_ADDR       = 32,
    parameter int BW_DATA       = 32,
    parameter int BW_LPI_BURDEN = 1,
    parameter int ROUTE_DEPTH   = 4,
    localparam int BW_LPIXM_QPARCEL = lpixm_qparcel_width(BW_ADDR, BW_DATA, BW_LPI_BURDEN),
    localparam int BW_LPIXM_YPARCEL = lpixm_yparcel_width(BW_DATA, BW_LPI_BURDEN)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        s0_qvalid,
    output logic                        s0_qready,
    input  logic [BW_LPIXM_QPARCEL-1:0] s0_qparcel,
    output logic                        s0_yvalid,
    input  logic                        s0_yready,
    output logic [BW_LPIXM_YPARCEL-1:0] s0_yparcel,
    input  logic                        s1_qvalid,
    output logic                        s1_qready,
    input  logic [BW_LPIXM_QPARCEL-1:0] s1_qparcel,
    output logic                        s1_yvalid,
    input  logic                        s1_yready,
    output logic [BW_LPIXM_YPARCEL-1:0] s1_yparcel,
    output logic                        m_qvalid,
    input  logic                        m_qready,
    output logic [BW_LPIXM_QPARCEL-1:0] m_qparcel,
    input  logic                        m_yvalid,
    output logic                        m_yready,
    input  logic [BW_LPIXM_YPARCEL-1:0] m_yparcel
);
    logic                                srst;
    logic [1:0]                          s_qvalid;
    logic [1:0]                          s_qready;
    logic [1:0]                          s_yvalid;
    logic [1:0]                          s_yready;
    logic [1:0][BW_LPIXM_QPARCEL-1:0]    s_qparcel;

    arb_state_e                          state_reg;
    logic                                owner_reg;
    logic                                rr_ptr_reg;
    logic [BW_AXI_ALEN-1:0]              beat_cnt_reg;
    logic [BW_AXI_ALEN-1:0]              y_cnt_reg;

    logic                                grant_valid;
    logic                                grant_id;
    logic [BW_LPIXM_QPARCEL-1:0]         grant_parcel;
    logic                                head_write;
    logic [BW_AXI_ALEN-1:0]              head_alen;
    logic                                q_fire;
    logic                                y_fire;
    logic                                fifo_push;
    logic                                fifo_pop;
    logic                                fifo_full;
    logic                                fifo_empty;
    logic [BW_ROUTE_ENTRY-1:0]           fifo_wdata;
    logic [BW_ROUTE_ENTRY-1:0]           fifo_rdata;
    logic                                route_id;
    logic [BW_AXI_ALEN-1:0]              route_ybeats;

    assign srst      = rst | clear;
    assign s_qvalid  = {s1_qvalid, s0_qvalid};
    assign s_yready  = {s1_yready, s0_yready};
    assign s_qparcel = {s1_qparcel, s0_qparcel};
    assign s0_qready = s_qready[0];
    assign s1_qready = s_qready[1];
    assign s0_yvalid = s_yvalid[0];
    assign s1_yvalid = s_yvalid[1];
    assign s0_yparcel = m_yparcel;
    assign s1_yparcel = m_yparcel;

    // A locked burst keeps going regardless of route-FIFO fullness: only its head was routed.
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = 1'b0;
        if (state_reg == ST_LOCK) begin
            grant_id    = owner_reg;
            grant_valid = s_qvalid[owner_reg];
        end else if (!fifo_full) begin
            grant_valid = |s_qvalid;
            grant_id    = (&s_qvalid) ? rr_ptr_reg : s_qvalid[1];
        end
    end

    assign grant_parcel = grant_valid ? s_qparcel[grant_id] : '0;
    assign m_qvalid     = grant_valid;
    assign m_qparcel    = grant_parcel;
    assign q_fire       = grant_valid && m_qready;

    assign head_write = lpixm_get_write(lpixm_parcel_max_t'(grant_parcel), BW_ADDR, BW_DATA);
    assign head_alen  = lpixm_get_alen(lpixm_parcel_max_t'(grant_parcel), BW_ADDR, BW_DATA);

    assign route_id     = fifo_rdata[BW_ROUTE_ENTRY-1];
    assign route_ybeats = fifo_rdata[BW_AXI_ALEN-1:0];
    assign m_yready     = !fifo_empty && s_yready[route_id];
    assign y_fire       = m_yvalid && m_yready;

    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_req
        assign s_qready[gi] = q_fire && (grant_id == 1'(gi));
        assign s_yvalid[gi] = !fifo_empty && (route_id == 1'(gi)) && m_yvalid;
    end

    assign fifo_push  = q_fire && (state_reg == ST_IDLE);
    assign fifo_wdata = {grant_id, head_write ? {BW_AXI_ALEN{1'b0}} : head_alen};
    assign fifo_pop   = y_fire && (y_cnt_reg == route_ybeats);

    rvx_route_fifo #(
        .WIDTH (BW_ROUTE_ENTRY),
        .DEPTH (ROUTE_DEPTH)
    ) u_route_fifo (
        .clk   (clk),
        .srst  (srst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg    <= ST_IDLE;
            owner_reg    <= 1'b0;
            rr_ptr_reg   <= 1'b0;
            beat_cnt_reg <= '0;
            y_cnt_reg    <= '0;
        end else begin
            if (q_fire) begin
                if (state_reg == ST_IDLE) begin
                    if (head_write && (head_alen != '0)) begin
                        state_reg    <= ST_LOCK;
                        owner_reg    <= grant_id;
                        beat_cnt_reg <= head_alen;
                    end else begin
                        rr_ptr_reg <= ~grant_id;
                    end
                end else begin
                    beat_cnt_reg <= beat_cnt_reg - 1'b1;
                    if (beat_cnt_reg == BW_AXI_ALEN'(1)) begin
                        state_reg  <= ST_IDLE;
                        rr_ptr_reg <= ~owner_reg;
                    end
                end
            end
            if (y_fire) begin
                y_cnt_reg <= fifo_pop ? '0 : y_cnt_reg + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvx_lpixm_rr_arbiter.sv
// Self-checking bench: directed scenarios plus a randomized run scored against
// a burst-level reference model of the arbitration and response routing.
module tb_rvx_lpixm_rr_arbiter;
    import rvx_lpixm_rr_arbiter_pkg::*;

    localparam int QW    = lpixm_qparcel_width(32, 32, 1);
    localparam int YW    = lpixm_yparcel_width(32, 1);
    localparam int DEPTH = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 clear;
    logic [1:0]           sq_valid;
    logic [1:0]           sq_ready;
    logic [1:0][QW-1:0]   sq_parcel;
    logic [1:0]           sy_valid;
    logic [1:0]           sy_ready;
    logic [1:0][YW-1:0]   sy_parcel;
    logic                 m_qvalid;
    logic                 m_qready;
    logic [QW-1:0]        m_qparcel;
    logic                 m_yvalid;
    logic                 m_yready;
    logic [YW-1:0]        m_yparcel;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rvx_lpixm_rr_arbiter #(
        .BW_ADDR(32), .BW_DATA(32), .BW_LPI_BURDEN(1), .ROUTE_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .s0_qvalid(sq_valid[0]), .s0_qready(sq_ready[0]), .s0_qparcel(sq_parcel[0]),
        .s0_yvalid(sy_valid[0]), .s0_yready(sy_ready[0]), .s0_yparcel(sy_parcel[0]),
        .s1_qvalid(sq_valid[1]), .s1_qready(sq_ready[1]), .s1_qparcel(sq_parcel[1]),
        .s1_yvalid(sy_valid[1]), .s1_yready(sy_ready[1]), .s1_yparcel(sy_parcel[1]),
        .m_qvalid(m_qvalid), .m_qready(m_qready), .m_qparcel(m_qparcel),
        .m_yvalid(m_yvalid), .m_yready(m_yready), .m_yparcel(m_yparcel)
    );

    // {burden, write, alen, asize, aburst, byte-enable, wdata, addr}
    function automatic logic [QW-1:0] make_q(logic wr, logic [7:0] alen);
        logic [31:0] addr;
        logic [31:0] wdata;
        addr  = $urandom;
        wdata = $urandom;
        return {1'($urandom), wr, alen, 3'($urandom), 2'($urandom), 4'($urandom), wdata, addr};
    endfunction

    function automatic logic [YW-1:0] make_y();
        return {1'($urandom), 2'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; clear = 1'b0; sq_valid = '0; sq_parcel = '0; sy_ready = '0;
        m_qready = 1'b0; m_yvalid = 1'b0; m_yparcel = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [YW-1:0] y;
        apply_reset();
        y = make_y();
        m_yparcel = y;
        @(negedge clk);
        n_checks++; if (m_qvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_qvalid got=%b want=0", m_qvalid); end
        n_checks++; if (m_qparcel !== '0) begin n_fail++; $display("FAIL reset_m_qparcel got=%h want=0", m_qparcel); end
        n_checks++; if (sq_ready !== 2'b00) begin n_fail++; $display("FAIL reset_sq_ready got=%b want=00", sq_ready); end
        n_checks++; if (sy_valid !== 2'b00) begin n_fail++; $display("FAIL reset_sy_valid got=%b want=00", sy_valid); end
        n_checks++; if (m_yready !== 1'b0) begin n_fail++; $display("FAIL reset_m_yready got=%b want=0", m_yready); end
        n_checks++; if (sy_parcel[0] !== y || sy_parcel[1] !== y) begin n_fail++; $display("FAIL reset_yparcel got=%h/%h want=%h", sy_parcel[0], sy_parcel[1], y); end
        $display("test_reset done");
    endtask

    task automatic test_rr_reads();
        logic [QW-1:0] p0, p1, p2;
        logic [YW-1:0] y;
        logic [1:0] want_id [3];
        apply_reset();
        p0 = make_q(1'b0, 8'd0); p1 = make_q(1'b0, 8'd0); p2 = make_q(1'b0, 8'd0);
        m_qready = 1'b1; sq_valid = 2'b11; sq_parcel[0] = p0; sq_parcel[1] = p1;
        @(negedge clk);
        n_checks++; if (m_qparcel !== p0 || sq_ready !== 2'b01) begin n_fail++; $display("FAIL rr_first got=%h/%b want=%h/01", m_qparcel, sq_ready, p0); end
        tick();
        sq_parcel[0] = p2;
        @(negedge clk);
        n_checks++; if (m_qparcel !== p1 || sq_ready !== 2'b10) begin n_fail++; $display("FAIL rr_second got=%h/%b want=%h/10", m_qparcel, sq_ready, p1); end
        tick();
        sq_valid = 2'b01;
        @(negedge clk);
        n_checks++; if (m_qparcel !== p2 || sq_ready !== 2'b01) begin n_fail++; $display("FAIL rr_third got=%h/%b want=%h/01", m_qparcel, sq_ready, p2); end
        tick();
        sq_valid = 2'b00; m_qready = 1'b0; m_yvalid = 1'b1; sy_ready = 2'b11;
        want_id[0] = 2'b01; want_id[1] = 2'b10; want_id[2] = 2'b01;
        for (int i = 0; i < 3; i++) begin
            y = make_y();
            m_yparcel = y;
            @(negedge clk);
            n_checks++; if (sy_valid !== want_id[i] || m_yready !== 1'b1) begin n_fail++; $display("FAIL rr_resp%0d got=%b/%b want=%b/1", i, sy_valid, m_yready, want_id[i]); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (sy_valid !== 2'b00 || m_yready !== 1'b0) begin n_fail++; $display("FAIL rr_empty got=%b/%b want=00/0", sy_valid, m_yready); end
        $display("test_rr_reads done");
    endtask

    task automatic test_write_lock();
        logic [QW-1:0] w, r, rd0, r2;
        apply_reset();
        r = make_q(1'b0, 8'd0);
        m_qready = 1'b1; sq_parcel[1] = r;
        for (int b = 0; b < 5; b++) begin
            if (b == 2) begin
                sq_valid = 2'b10;
                @(negedge clk);
                n_checks++; if (m_qvalid !== 1'b0 || sq_ready !== 2'b00) begin n_fail++; $display("FAIL lock_gap got=%b/%b want=0/00", m_qvalid, sq_ready); end
            end else begin
                w = make_q(1'b1, 8'd3);
                sq_parcel[0] = w; sq_valid = 2'b11;
                @(negedge clk);
                n_checks++; if (m_qparcel !== w || sq_ready !== 2'b01) begin n_fail++; $display("FAIL lock_beat%0d got=%h/%b want=%h/01", b, m_qparcel, sq_ready, w); end
            end
            tick();
        end
        rd0 = make_q(1'b0, 8'd0);
        sq_parcel[0] = rd0; sq_valid = 2'b11;
        @(negedge clk);
        n_checks++; if (m_qparcel !== r || sq_ready !== 2'b10) begin n_fail++; $display("FAIL lock_after got=%h/%b want=%h/10", m_qparcel, sq_ready, r); end
        tick();
        r2 = make_q(1'b0, 8'd0);
        sq_parcel[1] = r2;
        @(negedge clk);
        n_checks++; if (m_qparcel !== rd0 || sq_ready !== 2'b01) begin n_fail++; $display("FAIL lock_rrptr got=%h/%b want=%h/01", m_qparcel, sq_ready, rd0); end
        $display("test_write_lock done");
    endtask

    task automatic test_fifo_full();
        logic [QW-1:0] p;
        apply_reset();
        m_qready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sq_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
            sq_parcel[i % 2] = make_q(1'b0, 8'd0);
            @(negedge clk);
            n_checks++; if (m_qvalid !== 1'b1) begin n_fail++; $display("FAIL full_fill%0d got=%b want=1", i, m_qvalid); end
            tick();
        end
        p = make_q(1'b0, 8'd0);
        sq_valid = 2'b01; sq_parcel[0] = p;
        @(negedge clk);
        n_checks++; if (m_qvalid !== 1'b0 || sq_ready !== 2'b00 || m_qparcel !== '0) begin n_fail++; $display("FAIL full_block got=%b/%b/%h want=0/00/0", m_qvalid, sq_ready, m_qparcel); end
        tick();
        m_yvalid = 1'b1; sy_ready = 2'b11;
        @(negedge clk);
        n_checks++; if (m_yready !== 1'b1 || m_qvalid !== 1'b0) begin n_fail++; $display("FAIL full_samepop got=%b/%b want=1/0", m_yready, m_qvalid); end
        tick();
        m_yvalid = 1'b0;
        @(negedge clk);
        n_checks++; if (m_qvalid !== 1'b1 || m_qparcel !== p) begin n_fail++; $display("FAIL full_admit got=%b/%h want=1/%h", m_qvalid, m_qparcel, p); end
        tick();
        sq_valid = 2'b10; sq_parcel[1] = make_q(1'b0, 8'd0);
        @(negedge clk);
        n_checks++; if (m_qvalid !== 1'b0) begin n_fail++; $display("FAIL full_again got=%b want=0", m_qvalid); end
        clear = 1'b1;
        tick();
        clear = 1'b0; m_yvalid = 1'b1;
        @(negedge clk);
        n_checks++; if (sq_ready !== 2'b10 || m_yready !== 1'b0 || sy_valid !== 2'b00) begin n_fail++; $display("FAIL clear_state got=%b/%b/%b want=10/0/00", sq_ready, m_yready, sy_valid); end
        $display("test_fifo_full done");
    endtask

    task automatic test_burst_read();
        logic [YW-1:0] y;
        apply_reset();
        m_qready = 1'b1; sq_valid = 2'b10; sq_parcel[1] = make_q(1'b0, 8'd2);
        tick();
        sq_valid = 2'b00; m_yvalid = 1'b1; sy_ready = 2'b11;
        for (int b = 0; b < 3; b++) begin
            y = make_y();
            m_yparcel = y;
            @(negedge clk);
            n_checks++; if (sy_valid !== 2'b10 || m_yready !== 1'b1 || sy_parcel[1] !== y) begin n_fail++; $display("FAIL burst_beat%0d got=%b/%b/%h want=10/1/%h", b, sy_valid, m_yready, sy_parcel[1], y); end
            tick();
        end
        @(negedge clk);
        n_checks++; if (sy_valid !== 2'b00 || m_yready !== 1'b0) begin n_fail++; $display("FAIL burst_popped got=%b/%b want=00/0", sy_valid, m_yready); end
        $display("test_burst_read done");
    endtask

    task automatic test_backpressure();
        logic [YW-1:0] y;
        apply_reset();
        m_qready = 1'b1; sq_valid = 2'b01; sq_parcel[0] = make_q(1'b0, 8'd0);
        tick();
        sq_valid = 2'b00; y = make_y(); m_yparcel = y; m_yvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sy_ready = (i == 2) ? 2'b10 : 2'b00;
            @(negedge clk);
            n_checks++; if (m_yready !== 1'b0 || sy_valid !== 2'b01 || sy_parcel[0] !== y) begin n_fail++; $display("FAIL bp_hold%0d got=%b/%b/%h want=0/01/%h", i, m_yready, sy_valid, sy_parcel[0], y); end
            tick();
        end
        sy_ready = 2'b01;
        @(negedge clk);
        n_checks++; if (m_yready !== 1'b1) begin n_fail++; $display("FAIL bp_release got=%b want=1", m_yready); end
        tick();
        @(negedge clk);
        n_checks++; if (m_yready !== 1'b0) begin n_fail++; $display("FAIL bp_popped got=%b want=0", m_yready); end
        $display("test_backpressure done");
    endtask

    task automatic test_reset_mid_lock();
        apply_reset();
        m_qready = 1'b1; sq_valid = 2'b11; sq_parcel[1] = make_q(1'b0, 8'd0);
        for (int b = 0; b < 2; b++) begin
            sq_parcel[0] = make_q(1'b1, 8'd3);
            tick();
        end
        sq_parcel[0] = make_q(1'b1, 8'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0; sq_valid = 2'b00; m_yvalid = 1'b1; sy_ready = 2'b11;
        @(negedge clk);
        n_checks++; if (m_qvalid !== 1'b0 || sq_ready !== 2'b00 || m_qparcel !== '0) begin n_fail++; $display("FAIL rstlock_q got=%b/%b/%h want=0/00/0", m_qvalid, sq_ready, m_qparcel); end
        n_checks++; if (sy_valid !== 2'b00 || m_yready !== 1'b0) begin n_fail++; $display("FAIL rstlock_y got=%b/%b want=00/0", sy_valid, m_yready); end
        tick();
        m_yvalid = 1'b0; sq_valid = 2'b10;
        @(negedge clk);
        n_checks++; if (sq_ready !== 2'b10) begin n_fail++; $display("FAIL rstlock_idle got=%b want=10", sq_ready); end
        $display("test_reset_mid_lock done");
    endtask

    task automatic test_random();
        int lock_owner, lock_left, rr, y_seen, g, hid;
        int route_id_q[$];
        int route_cnt_q[$];
        int left[2];
        logic cur_wr[2];
        logic [7:0] cur_alen[2];
        logic [1:0] fired, exp_ready, exp_syv;
        logic exp_myr;
        logic [QW-1:0] exp_qp;
        apply_reset();
        lock_owner = -1; lock_left = 0; rr = 0; y_seen = 0;
        left[0] = 0; left[1] = 0; fired = 2'b00;
        for (int cyc = 0; cyc < 800; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if (fired[k]) begin sq_valid[k] = 1'b0; left[k]--; end
                if (!sq_valid[k]) begin
                    if (left[k] == 0) begin
                        if ($urandom_range(2) != 0) begin
                            cur_wr[k] = 1'($urandom); cur_alen[k] = 8'($urandom_range(3));
                            left[k] = cur_wr[k] ? int'(cur_alen[k]) + 1 : 1;
                            sq_parcel[k] = make_q(cur_wr[k], cur_alen[k]); sq_valid[k] = 1'b1;
                        end
                    end else if ($urandom_range(3) != 0) begin
                        sq_parcel[k] = make_q(cur_wr[k], cur_alen[k]); sq_valid[k] = 1'b1;
                    end
                end
            end
            m_qready = ($urandom_range(3) != 0); m_yvalid = ($urandom_range(2) != 0);
            m_yparcel = make_y(); sy_ready = 2'($urandom);
            @(negedge clk);
            g = -1;
            if (lock_owner >= 0) begin
                if (sq_valid[lock_owner]) g = lock_owner;
            end else if (route_id_q.size() < DEPTH) begin
                if (sq_valid == 2'b11) g = rr;
                else if (sq_valid[0]) g = 0;
                else if (sq_valid[1]) g = 1;
            end
            exp_qp = (g >= 0) ? sq_parcel[g] : '0;
            exp_ready = 2'b00; exp_syv = 2'b00; exp_myr = 1'b0;
            if (g >= 0 && m_qready) exp_ready[g] = 1'b1;
            if (route_id_q.size() > 0) begin
                hid = route_id_q[0]; exp_syv[hid] = m_yvalid; exp_myr = sy_ready[hid];
            end
            n_checks++; if (m_qvalid !== (g >= 0)) begin n_fail++; $display("FAIL rnd_qvalid cyc=%0d got=%b want=%b", cyc, m_qvalid, g >= 0); end
            n_checks++; if (m_qparcel !== exp_qp) begin n_fail++; $display("FAIL rnd_qparcel cyc=%0d got=%h want=%h", cyc, m_qparcel, exp_qp); end
            n_checks++; if (sq_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_qready cyc=%0d got=%b want=%b", cyc, sq_ready, exp_ready); end
            n_checks++; if (sy_valid !== exp_syv) begin n_fail++; $display("FAIL rnd_yvalid cyc=%0d got=%b want=%b", cyc, sy_valid, exp_syv); end
            n_checks++; if (m_yready !== exp_myr) begin n_fail++; $display("FAIL rnd_yready cyc=%0d got=%b want=%b", cyc, m_yready, exp_myr); end
            n_checks++; if (sy_parcel[0] !== m_yparcel || sy_parcel[1] !== m_yparcel) begin n_fail++; $display("FAIL rnd_yparcel cyc=%0d got=%h/%h want=%h", cyc, sy_parcel[0], sy_parcel[1], m_yparcel); end
            fired = exp_ready;
            if (g >= 0 && m_qready) begin
                $display("q s%0d %s parcel=%h", g, (lock_owner < 0) ? "head" : "beat", sq_parcel[g]);
                if (lock_owner < 0) begin
                    route_id_q.push_back(g);
                    route_cnt_q.push_back(cur_wr[g] ? 1 : int'(cur_alen[g]) + 1);
                    if (cur_wr[g] && cur_alen[g] != 8'd0) begin lock_owner = g; lock_left = int'(cur_alen[g]); end
                    else rr = 1 - g;
                end else begin
                    lock_left--;
                    if (lock_left == 0) begin rr = 1 - lock_owner; lock_owner = -1; end
                end
            end
            if (exp_myr && m_yvalid) begin
                $display("y s%0d parcel=%h", route_id_q[0], m_yparcel);
                y_seen++;
                if (y_seen == route_cnt_q[0]) begin
                    void'(route_id_q.pop_front()); void'(route_cnt_q.pop_front()); y_seen = 0;
                end
            end
            tick();
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_rr_reads();
        test_write_lock();
        test_fifo_full();
        test_burst_read();
        test_backpressure();
        test_reset_mid_lock();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rvx_lpixm_rr_arbiter.md
RVX_LPIXM_RR_ARBITER -- requirements
Module: rvx_lpixm_rr_arbiter

Interface
REQ-001 SHALL have parameter BW_ADDR, default 32: request address width.
REQ-002 SHALL have parameter BW_DATA, default 32: data width.
REQ-003 SHALL have parameter BW_LPI_BURDEN, default 1: opaque burden width carried in each parcel.
REQ-004 SHALL have parameter ROUTE_DEPTH, default 4: number of outstanding bursts tracked (power of 2, at least 2).
REQ-005 SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear  in  1  synchronous soft clear, same effect as rst.
REQ-007 SHALL have, for requester k = 0,1, ports: sk_qvalid in 1; sk_qready out 1; sk_qparcel in BW_LPIXM_QPARCEL  request parcel {burden, write, alen, asize, aburst, byte-enable, wdata, addr}.
REQ-008 SHALL have, for requester k = 0,1, ports: sk_yvalid out 1; sk_yready in 1; sk_yparcel out BW_LPIXM_YPARCEL  response parcel.
REQ-009 SHALL have shared-slave ports: m_qvalid out 1; m_qready in 1; m_qparcel out BW_LPIXM_QPARCEL; m_yvalid in 1; m_yready out 1; m_yparcel in BW_LPIXM_YPARCEL.

Function
REQ-010 SHALL transfer a parcel on any channel only in a cycle where valid and ready are both 1.
REQ-011 SHALL treat a burst as follows: write with alen=L is L+1 consecutive q parcels and returns 1 y parcel; read is 1 q parcel and returns alen+1 y parcels.
REQ-012 SHALL run FSM IDLE/LOCK; reset state IDLE, owner=0, rr_ptr=0.
REQ-013 SHALL in IDLE grant combinationally: if one requester is valid, grant it; if both are valid, grant rr_ptr; grant-to-m_qvalid latency 0 cycles.
REQ-014 SHALL in IDLE hold m_qvalid and both sk_qready at 0 while the route FIFO is full.
REQ-015 SHALL in IDLE on acceptance of a write burst head with alen>0 latch owner, load beat counter with alen, and go to LOCK.
REQ-016 SHALL in LOCK forward only the owner, forcing the other requester's qready to 0.
REQ-017 SHALL in LOCK decrement the beat counter per accepted parcel and return to IDLE on the parcel accepted at count 1.
REQ-018 SHALL in LOCK ignore route-FIFO fullness.
REQ-019 SHALL toggle rr_ptr to the opposite of the granted requester when a burst completes, i.e. on the last q parcel accepted.
REQ-020 SHALL on every burst-head acceptance push {requester id, ybeats} into the route FIFO, where ybeats = write ? 0 : alen.
REQ-021 SHALL not push into a full FIFO, even if a pop occurs in the same cycle.
REQ-022 SHALL route responses in order: with FIFO non-empty, sk_yvalid = m_yvalid for head id k and 0 for the other; m_yready = sk_yready of the head id.
REQ-023 SHALL with the FIFO empty hold m_yready=0 and both sk_yvalid=0.
REQ-024 SHALL count y beats accepted and pop the FIFO on the beat that equals ybeats.
REQ-025 SHALL drive sk_yparcel = m_yparcel unmodified to both requesters.
REQ-026 SHALL pass m_qparcel = the granted sk_qparcel unmodified, and drive m_qparcel to 0 when no requester is granted.
REQ-027 SHALL support a push and a pop in the same cycle when the FIFO is non-full; occupancy is then unchanged.

Reset
REQ-028 SHALL on rst or clear in the next cycle set: FSM IDLE, rr_ptr 0, beat/y counters 0, FIFO empty.
REQ-029 SHALL, as a consequence of REQ-028, give reset outputs sk_qready=0, sk_yvalid=0, m_qvalid=0, m_yready=0, m_qparcel=0.
REQ-030 SHALL on reset mid-burst abandon the burst; outstanding responses are then not routed (system-level reset assumed).

Structure
REQ-031 SHALL take parcel widths and field extractors (write, alen) from the shared lpixm function package; route entry width localparam = 1 + BW_AXI_ALEN.
REQ-032 SHALL implement the route FIFO as one sub-module, rvx_route_fifo (synchronous, depth ROUTE_DEPTH, push/pop/full/empty).

Verification
REQ-033 SHALL cover: both valid, single-beat reads, rr_ptr=0 -> grants s0 then s1 in consecutive cycles, responses returned to s0 then s1.
REQ-034 SHALL cover: s0 write alen=3 with s1 valid throughout -> 4 s0 parcels contiguous, s1_qready=0, then s1 granted, rr_ptr=0.
REQ-035 SHALL cover: 4 reads outstanding with ROUTE_DEPTH=4 and m_yvalid=0 -> fifth head blocked (m_qvalid=0); first y pop in the same cycle still does not admit it.
REQ-036 SHALL cover: s1 read alen=2 -> exactly 3 y beats to s1 with s0_yvalid=0; FIFO pops on the 3rd beat.
REQ-037 SHALL cover: sk_yready=0 backpressure -> m_yready=0 and m_yparcel held until ready.
REQ-038 SHALL cover: rst asserted in LOCK after 2 of 4 beats -> next cycle IDLE with all outputs per REQ-029.
